// File: rtl/data_capture_engine_if.sv
// data_capture_engine_if
//   Bundles the capture engine's sample, configuration, readback and status
//   signals so the engine and its driver share one connection.
//   Clock and reset are not part of the bundle; they stay plain ports.
// Signals (direction as seen by the engine, modport slave):
//   DATA_IN        in   C_NUM_LANES      lane data, synchronous to the clock
//   DATA_VALID     in   1                DATA_IN holds a sample this cycle
//   TRIG_IN        in   1                trigger level; the engine detects the rising edge
//   CFG_START      in   1                pulse: latch configuration and start a capture
//   CFG_ABORT      in   1                pulse: stop the capture, return to idle
//   CFG_MODE       in   2                0/3 immediate, 1 triggered, 2 continuous
//   CFG_DECIM      in   C_DECIM_W        keep 1 of every CFG_DECIM+1 valid samples
//   CFG_POST_CNT   in   C_DEPTH_LOG2     samples kept after the trigger sample
//   RD_ADDR        in   C_RA_W           readback word address
//   RD_DATA        out  C_RD_WIDTH       readback word, one cycle after RD_ADDR
//   STAT_BUSY      out  1                armed or post-trigger
//   STAT_DONE      out  1                sticky capture complete
//   STAT_WRAP      out  1                sticky write pointer wrapped
//   STAT_TRIG_ADDR out  C_DEPTH_LOG2     sample address of the trigger sample
//   P12_SEL        out  1                front-end select, follows STAT_BUSY
interface data_capture_engine_if #(
  parameter int C_NUM_LANES  = 4,
  parameter int C_DEPTH_LOG2 = 13,
  parameter int C_RD_WIDTH   = 32,
  parameter int C_DECIM_W    = 8
);
  localparam int C_RA_W = C_DEPTH_LOG2 - $clog2(C_RD_WIDTH / C_NUM_LANES);

  logic [C_NUM_LANES-1:0]  DATA_IN;
  logic                    DATA_VALID;
  logic                    TRIG_IN;
  logic                    CFG_START;
  logic                    CFG_ABORT;
  logic [1:0]              CFG_MODE;
  logic [C_DECIM_W-1:0]    CFG_DECIM;
  logic [C_DEPTH_LOG2-1:0] CFG_POST_CNT;
  logic [C_RA_W-1:0]       RD_ADDR;
  logic [C_RD_WIDTH-1:0]   RD_DATA;
  logic                    STAT_BUSY;
  logic                    STAT_DONE;
  logic                    STAT_WRAP;
  logic [C_DEPTH_LOG2-1:0] STAT_TRIG_ADDR;
  logic                    P12_SEL;

  modport master (
    output DATA_IN, DATA_VALID, TRIG_IN, CFG_START, CFG_ABORT,
           CFG_MODE, CFG_DECIM, CFG_POST_CNT, RD_ADDR,
    input  RD_DATA, STAT_BUSY, STAT_DONE, STAT_WRAP, STAT_TRIG_ADDR, P12_SEL
  );

  modport slave (
    input  DATA_IN, DATA_VALID, TRIG_IN, CFG_START, CFG_ABORT,
           CFG_MODE, CFG_DECIM, CFG_POST_CNT, RD_ADDR,
    output RD_DATA, STAT_BUSY, STAT_DONE, STAT_WRAP, STAT_TRIG_ADDR, P12_SEL
  );
endinterface

// File: rtl/data_capture_engine.sv
// data_capture_engine
//   Sample-capture engine: stores C_NUM_LANES-bit samples into a
//   2^C_DEPTH_LOG2-sample circular buffer in immediate, triggered or
//   continuous mode, with optional decimation, and reads the buffer back as
//   packed C_RD_WIDTH-bit words.
// Ports:
//   S_AXI_ACLK    in  clock, rising edge, for all logic
//   S_AXI_ARESET  in  synchronous active-high reset
//   bus           slave side of data_capture_engine_if (sample input,
//                 configuration pulses, readback address/data, status)
module data_capture_engine #(
  parameter int C_NUM_LANES  = 4,
  parameter int C_DEPTH_LOG2 = 13,
  parameter int C_RD_WIDTH   = 32,
  parameter int C_DECIM_W    = 8
) (
  input logic                  S_AXI_ACLK,
  input logic                  S_AXI_ARESET,
  data_capture_engine_if.slave bus
);

  localparam int C_K      = C_RD_WIDTH / C_NUM_LANES;
  localparam int C_K_LOG2 = $clog2(C_K);
  localparam int C_WA     = C_DEPTH_LOG2 - C_K_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [1:0]              r_mode;
  logic [C_DECIM_W-1:0]    r_decim;
  logic [C_DEPTH_LOG2-1:0] r_post;
  logic [C_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [C_DECIM_W-1:0]    r_dcnt;
  logic [C_DEPTH_LOG2-1:0] r_remaining;
  logic                    r_trig_prev;
  logic                    r_done;
  logic                    r_wrap;
  logic [C_DEPTH_LOG2-1:0] r_trig_addr;
  logic                    r_busy;
  logic                    r_p12;

  logic                    w_busy_state;
  logic                    w_next_busy;
  logic                    w_start_ok;
  logic                    w_accept;
  logic                    w_wr_en;
  logic                    w_trig_edge;
  logic                    w_trig_hit;
  logic                    w_last;
  logic [C_WA-1:0]         w_wr_word;
  logic [C_RD_WIDTH-1:0]   w_rd_word;

  assign w_busy_state = (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_next_busy  = (w_state_next == ST_ARMED) || (w_state_next == ST_POST);
  // Abort beats a coincident start.
  assign w_start_ok   = bus.CFG_START && !bus.CFG_ABORT &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // The abort cycle itself must not write.
  assign w_accept     = w_busy_state && !bus.CFG_ABORT && bus.DATA_VALID &&
                        (r_dcnt == '0);
  assign w_wr_en      = w_accept && !S_AXI_ARESET;
  // r_trig_prev holds the level seen in the START cycle, so an edge there
  // is never seen as an edge in the first armed cycle.
  assign w_trig_edge  = bus.TRIG_IN && !r_trig_prev;
  assign w_trig_hit   = (r_state == ST_ARMED) && (r_mode == 2'd1) &&
                        w_accept && w_trig_edge;
  // r_remaining counts samples still to store after the current one.
  assign w_last       = (r_state == ST_POST) && w_accept && (r_remaining == '0);
  assign w_wr_word    = C_WA'(r_wr_ptr >> C_K_LOG2);

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    if (bus.CFG_ABORT) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.CFG_START) begin
            w_state_next = ((bus.CFG_MODE == 2'd1) || (bus.CFG_MODE == 2'd2)) ?
                           ST_ARMED : ST_POST;
          end
        end
        ST_ARMED: begin
          // A zero post count means the trigger sample is the whole record.
          if (w_trig_hit) w_state_next = (r_post == '0) ? ST_DONE : ST_POST;
        end
        ST_POST: begin
          if (w_last) w_state_next = ST_DONE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) r_state <= ST_IDLE;
    else              r_state <= w_state_next;
  end

  // Capture datapath: pointers, decimation, post-trigger count, status.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_mode      <= '0;
      r_decim     <= '0;
      r_post      <= '0;
      r_wr_ptr    <= '0;
      r_dcnt      <= '0;
      r_remaining <= '0;
      r_trig_prev <= 1'b0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
      r_trig_addr <= '0;
      r_busy      <= 1'b0;
      r_p12       <= 1'b0;
    end else begin
      r_trig_prev <= bus.TRIG_IN;
      r_busy      <= w_next_busy;
      r_p12       <= w_next_busy;
      if (w_start_ok) begin
        r_mode      <= bus.CFG_MODE;
        r_decim     <= bus.CFG_DECIM;
        r_post      <= bus.CFG_POST_CNT;
        r_wr_ptr    <= '0;
        r_dcnt      <= '0;
        r_done      <= 1'b0;
        r_wrap      <= 1'b0;
        r_trig_addr <= '0;
        // Immediate mode fills the whole buffer; the triggered modes
        // reload this at the trigger.
        r_remaining <= '1;
      end else if (w_busy_state && !bus.CFG_ABORT) begin
        if (bus.DATA_VALID) begin
          r_dcnt <= (r_dcnt == '0) ? r_decim : r_dcnt - 1'b1;
        end
        if (w_accept) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_wr_ptr == '1) r_wrap <= 1'b1;
        end
        if (w_trig_hit) begin
          r_trig_addr <= r_wr_ptr;
          r_remaining <= r_post - 1'b1;
          if (r_post == '0) r_done <= 1'b1;
        end
        if (w_last) begin
          r_done <= 1'b1;
        end else if ((r_state == ST_POST) && w_accept) begin
          r_remaining <= r_remaining - 1'b1;
        end
      end
    end
  end

  // One narrow bank per sample slot within a readback word, so every sample
  // write is a plain full-width RAM write and readback concatenates the
  // banks. Each bank is read-first with a registered output.
  genvar gi;
  generate
    for (gi = 0; gi < C_K; gi++) begin : g_bank
      logic [C_NUM_LANES-1:0] r_mem [0:(1<<C_WA)-1];
      logic [C_NUM_LANES-1:0] r_rd_lane;
      logic                   w_we;

      assign w_we = w_wr_en && ((int'(r_wr_ptr) % C_K) == gi);

      always_ff @(posedge S_AXI_ACLK) begin
        if (w_we) r_mem[w_wr_word] <= bus.DATA_IN;
        if (S_AXI_ARESET) r_rd_lane <= '0;
        else              r_rd_lane <= r_mem[bus.RD_ADDR];
      end

      assign w_rd_word[gi*C_NUM_LANES +: C_NUM_LANES] = r_rd_lane;
    end
  endgenerate

  assign bus.RD_DATA        = w_rd_word;
  assign bus.STAT_BUSY      = r_busy;
  assign bus.STAT_DONE      = r_done;
  assign bus.STAT_WRAP      = r_wrap;
  assign bus.STAT_TRIG_ADDR = r_trig_addr;
  assign bus.P12_SEL        = r_p12;

endmodule

// File: tb/tb_data_capture_engine.sv
// tb_data_capture_engine
//   Directed bench for data_capture_engine. Stimulus pushes expected values
//   (with the cycle they become due) into a scoreboard queue; a monitor on
//   the falling edge pops and compares them against the DUT outputs.
module tb_data_capture_engine;

  localparam int RA_W = 10;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  data_capture_engine_if #(
    .C_NUM_LANES(4), .C_DEPTH_LOG2(13), .C_RD_WIDTH(32), .C_DECIM_W(8)
  ) bus ();

  data_capture_engine #(
    .C_NUM_LANES(4), .C_DEPTH_LOG2(13), .C_RD_WIDTH(32), .C_DECIM_W(8)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(srst),
    .bus         (bus)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_act(int sel);
    case (sel)
      0:       return bus.RD_DATA;
      1:       return {31'b0, bus.STAT_BUSY};
      2:       return {31'b0, bus.STAT_DONE};
      3:       return {31'b0, bus.STAT_WRAP};
      4:       return 32'(bus.STAT_TRIG_ADDR);
      default: return {31'b0, bus.P12_SEL};
    endcase
  endfunction

  // Monitor: compare every entry that has come due.
  chk_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e   = sbq.pop_front();
      mon_act = get_act(mon_e.sel);
      n_checks++;
      if (mon_e.due == cyc && mon_act === mon_e.exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %h, expected %h (cycle %0d)",
                 mon_e.name, mon_act, mon_e.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(int sel, logic [31:0] v, string nm);
    sbq.push_back('{due: cyc, sel: sel, exp: v, name: nm});
  endtask

  task automatic status(logic busy, logic done, logic wrap, int trig, string tag);
    expect_now(1, {31'b0, busy}, {tag, ".busy"});
    expect_now(5, {31'b0, busy}, {tag, ".p12"});
    expect_now(2, {31'b0, done}, {tag, ".done"});
    expect_now(3, {31'b0, wrap}, {tag, ".wrap"});
    expect_now(4, 32'(trig), {tag, ".trig_addr"});
  endtask

  task automatic rd(int a, logic [31:0] v, string nm);
    bus.RD_ADDR = RA_W'(a);
    sbq.push_back('{due: cyc + 1, sel: 0, exp: v, name: nm});
    tick();
  endtask

  task automatic start(logic [1:0] mode, logic [7:0] decim, logic [12:0] post);
    bus.DATA_VALID   = 1'b0;
    bus.CFG_MODE     = mode;
    bus.CFG_DECIM    = decim;
    bus.CFG_POST_CNT = post;
    bus.CFG_START    = 1'b1;
    tick();
    bus.CFG_START    = 1'b0;
  endtask

  initial begin
    int cnt;
    bus.DATA_IN = '0; bus.DATA_VALID = 1'b0; bus.TRIG_IN = 1'b0;
    bus.CFG_START = 1'b0; bus.CFG_ABORT = 1'b0; bus.CFG_MODE = '0;
    bus.CFG_DECIM = '0; bus.CFG_POST_CNT = '0; bus.RD_ADDR = '0;

    // Reset state.
    tick(); tick();
    status(1'b0, 1'b0, 1'b0, 0, "reset");
    expect_now(0, 32'h0, "reset.rd_data");
    srst = 1'b0;
    tick();

    // Immediate mode, full buffer.
    start(2'd0, 8'd0, 13'd0);
    status(1'b1, 1'b0, 1'b0, 0, "imm.start");
    for (int i = 0; i < 8192; i++) begin
      bus.DATA_VALID = 1'b1;
      bus.DATA_IN    = 4'(i);
      tick();
      if (i == 8190) status(1'b1, 1'b0, 1'b0, 0, "imm.s8190");
    end
    bus.DATA_VALID = 1'b0;
    status(1'b0, 1'b1, 1'b1, 0, "imm.end");
    rd(0, 32'h76543210, "imm.w0");
    rd(1, 32'hFEDCBA98, "imm.w1");
    rd(1023, 32'hFEDCBA98, "imm.w1023");

    // Triggered mode, trigger at sample 5000, 100 post samples.
    start(2'd1, 8'd0, 13'd100);
    for (int i = 0; i <= 5100; i++) begin
      bus.DATA_VALID = 1'b1;
      bus.DATA_IN    = 4'(i + 1);
      bus.TRIG_IN    = (i >= 5000);
      tick();
      if (i == 4999) status(1'b1, 1'b0, 1'b0, 0, "trig.pre");
      if (i == 5099) status(1'b1, 1'b0, 1'b0, 5000, "trig.s5099");
    end
    bus.DATA_VALID = 1'b0;
    bus.TRIG_IN    = 1'b0;
    status(1'b0, 1'b1, 1'b0, 5000, "trig.end");
    rd(625, 32'h0FEDCBA9, "trig.w625");
    rd(637, 32'hFEDDCBA9, "trig.w637");
    rd(638, 32'h76543210, "trig.w638");

    // Decimation by 3 with DATA_VALID gaps, then abort.
    start(2'd0, 8'd2, 13'd0);
    cnt = 0;
    for (int c = 0; cnt < 48; c++) begin
      if (c % 5 == 4) begin
        bus.DATA_VALID = 1'b0;
        bus.DATA_IN    = 4'hF;
      end else begin
        bus.DATA_VALID = 1'b1;
        bus.DATA_IN    = 4'(cnt);
        cnt++;
      end
      tick();
    end
    status(1'b1, 1'b0, 1'b0, 0, "decim.run");
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = 4'(cnt);
    bus.CFG_ABORT  = 1'b1;
    tick();
    bus.CFG_ABORT  = 1'b0;
    bus.DATA_VALID = 1'b0;
    status(1'b0, 1'b0, 1'b0, 0, "decim.abort");
    rd(0, 32'h52FC9630, "decim.w0");
    rd(1, 32'hDA741EB8, "decim.w1");
    rd(2, 32'h87654321, "decim.w2");

    // Continuous mode, 20000 samples, triggers toggling, then abort.
    start(2'd2, 8'd0, 13'd0);
    for (int i = 0; i < 20000; i++) begin
      bus.DATA_VALID = 1'b1;
      bus.DATA_IN    = 4'(i >> 3);
      bus.TRIG_IN    = ((i >> 6) & 1) != 0;
      tick();
    end
    status(1'b1, 1'b0, 1'b1, 0, "cont.run");
    bus.TRIG_IN    = 1'b0;
    bus.DATA_IN    = 4'hA;
    bus.CFG_ABORT  = 1'b1;
    tick();
    bus.CFG_ABORT  = 1'b0;
    bus.DATA_VALID = 1'b0;
    status(1'b0, 1'b0, 1'b1, 0, "cont.abort");
    rd(0, 32'h00000000, "cont.w0");
    rd(1, 32'h11111111, "cont.w1");
    rd(451, 32'h33333333, "cont.w451");
    rd(452, 32'h44444444, "cont.w452");
    rd(1023, 32'hFFFFFFFF, "cont.w1023");

    // START while busy is ignored; START with ABORT aborts.
    start(2'd0, 8'd0, 13'd0);
    for (int i = 0; i < 10; i++) begin
      bus.DATA_VALID = 1'b1;
      bus.DATA_IN    = 4'hA;
      tick();
    end
    bus.CFG_MODE  = 2'd1;
    bus.CFG_START = 1'b1;
    tick();
    bus.CFG_START = 1'b0;
    status(1'b1, 1'b0, 1'b0, 0, "busy.start");
    bus.CFG_START = 1'b1;
    bus.CFG_ABORT = 1'b1;
    tick();
    bus.CFG_START  = 1'b0;
    bus.CFG_ABORT  = 1'b0;
    bus.DATA_VALID = 1'b0;
    status(1'b0, 1'b0, 1'b0, 0, "startabort");
    tick();
    status(1'b0, 1'b0, 1'b0, 0, "startabort.idle");
    rd(0, 32'hAAAAAAAA, "startabort.w0");
    rd(1, 32'h11111AAA, "startabort.w1");

    // Reset in the middle of POST, then a fresh triggered capture with a
    // zero post count.
    start(2'd0, 8'd0, 13'd0);
    for (int i = 0; i < 20; i++) begin
      bus.DATA_VALID = 1'b1;
      bus.DATA_IN    = 4'h5;
      tick();
    end
    srst        = 1'b1;
    bus.DATA_IN = 4'hC;
    tick();
    status(1'b0, 1'b0, 1'b0, 0, "rst.mid");
    expect_now(0, 32'h0, "rst.rd_data");
    srst = 1'b0;
    tick();
    bus.DATA_VALID = 1'b0;
    status(1'b0, 1'b0, 1'b0, 0, "rst.idle");
    rd(2, 32'h22225555, "rst.w2");
    start(2'd1, 8'd0, 13'd0);
    for (int i = 0; i < 4; i++) begin
      bus.DATA_VALID = 1'b1;
      bus.DATA_IN    = 4'(i + 2);
      bus.TRIG_IN    = (i == 3);
      tick();
      if (i == 2) status(1'b1, 1'b0, 1'b0, 0, "post0.pre");
    end
    bus.DATA_VALID = 1'b0;
    bus.TRIG_IN    = 1'b0;
    status(1'b0, 1'b1, 1'b0, 3, "post0.end");
    rd(0, 32'h55555432, "post0.w0");

    // Drain the scoreboard, bounded.
    for (int k = 0; k < 20 && sbq.size() > 0; k++) tick();
    if (sbq.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
